pong_engine_2p: RTL

Two-player, parametrised Pong core: two quadrature-driven vertical paddles, a ball with configurable size and speed, per-player scores, and a serve/play/game-over state machine. Sits beside the existing hvsync_generator. It consumes that block's pixel coordinates and display-enable, and drives 1-bit R/G/B. All game state updates once per frame on an internal frame tick.

---
 rtl/pong_engine_2p.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/pong_engine_2p.sv
// Two-player Pong core: quadrature paddles, ball physics and a scoring FSM.
// Game state advances once per frame tick; the pixel colour is registered.

module pong_paddle #(
    parameter int YW   = 9,
    parameter int PY0  = 184,
    parameter int PMIN = 8,
    parameter int PMAX = 360
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          quadA,
    input  logic          quadB,
    output logic [YW-1:0] pY
);
    logic [2:0] aSync, bSync;
    logic       stepEn, stepUp;

    assign stepEn = aSync[1] ^ aSync[2] ^ bSync[1] ^ bSync[2];
    assign stepUp = aSync[1] ^ bSync[2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aSync <= '0;
            bSync <= '0;
            pY    <= YW'(PY0);
        end else begin
            aSync <= {aSync[1:0], quadA};
            bSync <= {bSync[1:0], quadB};
            // A leading B moves the paddle up the screen
            if (stepEn) begin
                if (stepUp) begin
                    if (pY > YW'(PMIN)) pY <= pY - YW'(1);
                end else if (pY < YW'(PMAX)) begin
                    pY <= pY + YW'(1);
                end
            end
        end
    end
endmodule

module pong_engine_2p #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int XW           = 10,
    parameter int YW           = 9,
    parameter int WALL         = 8,
    parameter int BALL         = 16,
    parameter int BALL_SPEED   = 1,
    parameter int PADDLE_LEN   = 112,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_XL    = 16,
    parameter int PADDLE_XR    = 616,
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int FRAME_LINE   = 500
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [XW-1:0] pix_x,
    input  logic [YW-1:0] pix_y,
    input  logic          display_en,
    input  logic          quadA_p1,
    input  logic          quadB_p1,
    input  logic          quadA_p2,
    input  logic          quadB_p2,
    input  logic          start,
    output logic          vga_R,
    output logic          vga_G,
    output logic          vga_B,
    output logic [3:0]    score_p1,
    output logic [3:0]    score_p2,
    output logic          game_over,
    output logic          winner,
    output logic          frame_tick
);
    localparam int CW = $clog2(SERVE_FRAMES) + 1;
    localparam logic [XW:0] X_BALL = (XW+1)'(BALL);
    localparam logic [XW:0] X_SPD  = (XW+1)'(BALL_SPEED);
    localparam logic [XW:0] X_FL   = (XW+1)'(PADDLE_XL + PADDLE_W);
    localparam logic [XW:0] X_XL   = (XW+1)'(PADDLE_XL);
    localparam logic [XW:0] X_XR   = (XW+1)'(PADDLE_XR);
    localparam logic [XW:0] X_PW   = (XW+1)'(PADDLE_W);
    localparam logic [XW:0] X_H    = (XW+1)'(H_ACTIVE);
    localparam logic [XW:0] X_NETL = (XW+1)'(H_ACTIVE/2 - 2);
    localparam logic [XW:0] X_NETR = (XW+1)'(H_ACTIVE/2 + 1);
    localparam logic [YW:0] Y_BALL = (YW+1)'(BALL);
    localparam logic [YW:0] Y_SPD  = (YW+1)'(BALL_SPEED);
    localparam logic [YW:0] Y_WALL = (YW+1)'(WALL);
    localparam logic [YW:0] Y_BOT  = (YW+1)'(V_ACTIVE - WALL);
    localparam logic [YW:0] Y_BMAX = (YW+1)'(V_ACTIVE - WALL - BALL);
    localparam logic [YW:0] Y_LEN  = (YW+1)'(PADDLE_LEN);
    localparam logic [XW-1:0] BX0  = XW'((H_ACTIVE - BALL) / 2);
    localparam logic [YW-1:0] BY0  = YW'((V_ACTIVE - BALL) / 2);
    localparam logic [3:0]    WIN4 = 4'(WIN_SCORE);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE    = 2'd1,
        PLAY     = 2'd2,
        GAMEOVER = 2'd3
    } state_t;

    state_t        state, stateNx;
    logic [XW-1:0] ballX, ballXNx;
    logic [YW-1:0] ballY, ballYNx;
    logic          dirX, dirXNx, dirY, dirYNx;
    logic [CW-1:0] serveCnt, serveCntNx;
    logic [3:0]    score1Nx, score2Nx, s1Inc, s2Inc;
    logic          winnerNx;
    logic [YW-1:0] p1Y, p2Y;

    logic [XW:0] xE, xStep, pxE;
    logic [YW:0] yE, yStep, p1E, p2E, pyE;
    logic        dirYStep, ov1, ov2, hitL, hitR, missL, missR;
    logic        ballPix, padPix, wallPix, netPix;

    pong_paddle #(
        .YW(YW), .PY0((V_ACTIVE - PADDLE_LEN) / 2),
        .PMIN(WALL), .PMAX(V_ACTIVE - WALL - PADDLE_LEN)
    ) u_p1 (
        .clk(clk), .reset(reset), .quadA(quadA_p1), .quadB(quadB_p1), .pY(p1Y)
    );

    pong_paddle #(
        .YW(YW), .PY0((V_ACTIVE - PADDLE_LEN) / 2),
        .PMIN(WALL), .PMAX(V_ACTIVE - WALL - PADDLE_LEN)
    ) u_p2 (
        .clk(clk), .reset(reset), .quadA(quadA_p2), .quadB(quadB_p2), .pY(p2Y)
    );

    assign game_over = (state == GAMEOVER);
    assign xE  = {1'b0, ballX};
    assign yE  = {1'b0, ballY};
    assign p1E = {1'b0, p1Y};
    assign p2E = {1'b0, p2Y};
    assign s1Inc = score_p1 + 4'd1;
    assign s2Inc = score_p2 + 4'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            ballX      <= BX0;
            ballY      <= BY0;
            dirX       <= 1'b1;
            dirY       <= 1'b1;
            serveCnt   <= '0;
            score_p1   <= '0;
            score_p2   <= '0;
            winner     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state      <= stateNx;
            ballX      <= ballXNx;
            ballY      <= ballYNx;
            dirX       <= dirXNx;
            dirY       <= dirYNx;
            serveCnt   <= serveCntNx;
            score_p1   <= score1Nx;
            score_p2   <= score2Nx;
            winner     <= winnerNx;
            frame_tick <= (pix_x == '0) && (pix_y == YW'(FRAME_LINE));
        end
    end

    always_comb begin
        stateNx    = state;
        ballXNx    = ballX;
        ballYNx    = ballY;
        dirXNx     = dirX;
        dirYNx     = dirY;
        serveCntNx = serveCnt;
        score1Nx   = score_p1;
        score2Nx   = score_p2;
        winnerNx   = winner;
        yStep      = yE;
        dirYStep   = dirY;
        xStep      = xE;

        if (dirY) begin
            if (yE + Y_BALL + Y_SPD > Y_BOT) begin
                yStep    = Y_BMAX;
                dirYStep = 1'b0;
            end else begin
                yStep = yE + Y_SPD;
            end
        end else if (yE < Y_WALL + Y_SPD) begin
            yStep    = Y_WALL;
            dirYStep = 1'b1;
        end else begin
            yStep = yE - Y_SPD;
        end

        ov1   = (yE + Y_BALL > p1E) && (yE < p1E + Y_LEN);
        ov2   = (yE + Y_BALL > p2E) && (yE < p2E + Y_LEN);
        hitL  = !dirX && xE >= X_FL && xE < X_FL + X_SPD && ov1;
        hitR  = dirX && xE + X_BALL <= X_XR
                && xE + X_BALL + X_SPD > X_XR && ov2;
        missL = !dirX && xE < X_SPD;
        missR = dirX && xE + X_BALL + X_SPD > X_H;

        if (hitL)      xStep = X_FL;
        else if (hitR) xStep = X_XR - X_BALL;
        else if (dirX) xStep = xE + X_SPD;
        else           xStep = xE - X_SPD;

        if (frame_tick) begin
            unique case (state)
                IDLE: if (start) begin
                    stateNx    = SERVE;
                    serveCntNx = '0;
                end
                SERVE: if (serveCnt == CW'(SERVE_FRAMES - 1)) begin
                    stateNx    = PLAY;
                    serveCntNx = '0;
                end else begin
                    serveCntNx = serveCnt + CW'(1);
                end
                PLAY: if (missL || missR) begin
                    // the serve heads toward whoever lost the point
                    if (missL) score2Nx = s2Inc;
                    else       score1Nx = s1Inc;
                    ballXNx = BX0;
                    ballYNx = BY0;
                    dirXNx  = missR;
                    if ((missL && s2Inc == WIN4) || (missR && s1Inc == WIN4)) begin
                        stateNx  = GAMEOVER;
                        winnerNx = missL;
                    end else begin
                        stateNx    = SERVE;
                        serveCntNx = '0;
                    end
                end else begin
                    ballXNx = xStep[XW-1:0];
                    ballYNx = yStep[YW-1:0];
                    dirXNx  = hitL ? 1'b1 : (hitR ? 1'b0 : dirX);
                    dirYNx  = dirYStep;
                end
                GAMEOVER: if (start) begin
                    score1Nx   = '0;
                    score2Nx   = '0;
                    winnerNx   = 1'b0;
                    stateNx    = SERVE;
                    serveCntNx = '0;
                end
                default: stateNx = IDLE;
            endcase
        end
    end

    assign pxE = {1'b0, pix_x};
    assign pyE = {1'b0, pix_y};

    always_comb begin
        ballPix = pxE >= xE && pxE < xE + X_BALL
                  && pyE >= yE && pyE < yE + Y_BALL;
        padPix  = (pxE >= X_XL && pxE < X_XL + X_PW
                   && pyE >= p1E && pyE < p1E + Y_LEN)
                  || (pxE >= X_XR && pxE < X_XR + X_PW
                   && pyE >= p2E && pyE < p2E + Y_LEN);
        wallPix = pyE < Y_WALL || pyE >= Y_BOT;
        netPix  = pxE >= X_NETL && pxE <= X_NETR && !pix_y[3];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vga_R <= 1'b0;
            vga_G <= 1'b0;
            vga_B <= 1'b0;
        end else begin
            vga_R <= display_en && (ballPix || padPix || wallPix);
            vga_G <= display_en && (ballPix || padPix || wallPix || netPix);
            vga_B <= display_en && (ballPix || padPix || wallPix);
        end
    end
endmodule
